// File: rtl/rv_id_ex_reg_pkg.sv
// rtl/rv_id_ex_reg_pkg.sv - shared encodings, widths and control bundle for the ID/EX register
package rv_id_ex_reg_pkg;

   localparam int DMEM_BYTECTRL_W = 3;
   localparam int SRC_ALU_CTRL_W  = 4;
   localparam int SRC_RF_WD_W     = 2;
   localparam int BR_JP_W         = 2;
   localparam int REG_ADDR_W      = 5;

   localparam logic [BR_JP_W-1:0] BR_JP_NONE   = 2'b00;
   localparam logic [BR_JP_W-1:0] BR_JP_BRANCH = 2'b01;
   localparam logic [BR_JP_W-1:0] BR_JP_JALR   = 2'b10;
   localparam logic [BR_JP_W-1:0] BR_JP_JAL    = 2'b11;

   localparam logic BUBBLE_VALID   = 1'b0;
   localparam logic BUBBLE_RF_WE   = 1'b0;
   localparam logic BUBBLE_DMEM_WE = 1'b0;
   localparam logic BUBBLE_IS_LOAD = 1'b0;
   localparam logic [BR_JP_W-1:0] BUBBLE_IS_BR_JP = BR_JP_NONE;

   typedef struct packed {
      logic                       valid;
      logic                       is_load;
      logic                       alu_a_sel;
      logic                       alu_b_sel;
      logic                       dmem_we;
      logic                       rf_we;
      logic [SRC_ALU_CTRL_W-1:0]  alu_ctrl;
      logic [DMEM_BYTECTRL_W-1:0] dmem_bytectrl;
      logic [SRC_RF_WD_W-1:0]     rf_wd_pre_sel;
      logic [BR_JP_W-1:0]         is_br_jp;
   } ex_ctrl_t;

   // Only the fields that can cause architectural side effects are cleared.
   function automatic ex_ctrl_t make_bubble(input ex_ctrl_t c);
      ex_ctrl_t b;
      b          = c;
      b.valid    = BUBBLE_VALID;
      b.rf_we    = BUBBLE_RF_WE;
      b.dmem_we  = BUBBLE_DMEM_WE;
      b.is_load  = BUBBLE_IS_LOAD;
      b.is_br_jp = BUBBLE_IS_BR_JP;
      return b;
   endfunction

endpackage

// File: rtl/rv_id_ex_reg_if.sv
// rtl/rv_id_ex_reg_if.sv - Decode-side inputs, EX-stage outputs, stall and perf counters
interface rv_id_ex_reg_if #(
   parameter int XLEN = 32
);
   import rv_id_ex_reg_pkg::*;

   logic                       i_id_valid;
   logic [XLEN-1:0]            i_id_pc;
   logic [XLEN-1:0]            i_id_pc_plus_4;
   logic [XLEN-1:0]            i_id_rs1_data;
   logic [XLEN-1:0]            i_id_rs2_data;
   logic [XLEN-1:0]            i_id_imm;
   logic [REG_ADDR_W-1:0]      i_id_rs1;
   logic [REG_ADDR_W-1:0]      i_id_rs2;
   logic [REG_ADDR_W-1:0]      i_id_rd;
   logic                       i_id_rs1_use;
   logic                       i_id_rs2_use;
   logic [BR_JP_W-1:0]         i_id_is_br_jp;
   logic                       i_id_is_load;
   logic                       i_id_alu_a_sel;
   logic                       i_id_alu_b_sel;
   logic                       i_id_dmem_we;
   logic                       i_id_rf_we;
   logic [SRC_ALU_CTRL_W-1:0]  i_id_alu_ctrl;
   logic [DMEM_BYTECTRL_W-1:0] i_id_dmem_bytectrl;
   logic [SRC_RF_WD_W-1:0]     i_id_rf_wd_pre_sel;
   logic                       i_ex_hold;
   logic                       i_ex_flush;

   logic                       o_ex_valid;
   logic [XLEN-1:0]            o_ex_pc;
   logic [XLEN-1:0]            o_ex_pc_plus_4;
   logic [XLEN-1:0]            o_ex_rs1_data;
   logic [XLEN-1:0]            o_ex_rs2_data;
   logic [XLEN-1:0]            o_ex_imm;
   logic [REG_ADDR_W-1:0]      o_ex_rs1;
   logic [REG_ADDR_W-1:0]      o_ex_rs2;
   logic [REG_ADDR_W-1:0]      o_ex_rd;
   logic                       o_ex_rs1_use;
   logic                       o_ex_rs2_use;
   logic [BR_JP_W-1:0]         o_ex_is_br_jp;
   logic                       o_ex_is_load;
   logic                       o_ex_alu_a_sel;
   logic                       o_ex_alu_b_sel;
   logic                       o_ex_dmem_we;
   logic                       o_ex_rf_we;
   logic [SRC_ALU_CTRL_W-1:0]  o_ex_alu_ctrl;
   logic [DMEM_BYTECTRL_W-1:0] o_ex_dmem_bytectrl;
   logic [SRC_RF_WD_W-1:0]     o_ex_rf_wd_pre_sel;
   logic                       o_id_stall;
   logic [31:0]                o_perf_bubble_cnt;
   logic [31:0]                o_perf_flush_cnt;

   modport slave (
      input  i_id_valid, i_id_pc, i_id_pc_plus_4, i_id_rs1_data, i_id_rs2_data, i_id_imm,
             i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_use, i_id_rs2_use, i_id_is_br_jp,
             i_id_is_load, i_id_alu_a_sel, i_id_alu_b_sel, i_id_dmem_we, i_id_rf_we,
             i_id_alu_ctrl, i_id_dmem_bytectrl, i_id_rf_wd_pre_sel, i_ex_hold, i_ex_flush,
      output o_ex_valid, o_ex_pc, o_ex_pc_plus_4, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
             o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rs1_use, o_ex_rs2_use, o_ex_is_br_jp,
             o_ex_is_load, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_dmem_we, o_ex_rf_we,
             o_ex_alu_ctrl, o_ex_dmem_bytectrl, o_ex_rf_wd_pre_sel, o_id_stall,
             o_perf_bubble_cnt, o_perf_flush_cnt
   );

   modport master (
      output i_id_valid, i_id_pc, i_id_pc_plus_4, i_id_rs1_data, i_id_rs2_data, i_id_imm,
             i_id_rs1, i_id_rs2, i_id_rd, i_id_rs1_use, i_id_rs2_use, i_id_is_br_jp,
             i_id_is_load, i_id_alu_a_sel, i_id_alu_b_sel, i_id_dmem_we, i_id_rf_we,
             i_id_alu_ctrl, i_id_dmem_bytectrl, i_id_rf_wd_pre_sel, i_ex_hold, i_ex_flush,
      input  o_ex_valid, o_ex_pc, o_ex_pc_plus_4, o_ex_rs1_data, o_ex_rs2_data, o_ex_imm,
             o_ex_rs1, o_ex_rs2, o_ex_rd, o_ex_rs1_use, o_ex_rs2_use, o_ex_is_br_jp,
             o_ex_is_load, o_ex_alu_a_sel, o_ex_alu_b_sel, o_ex_dmem_we, o_ex_rf_we,
             o_ex_alu_ctrl, o_ex_dmem_bytectrl, o_ex_rf_wd_pre_sel, o_id_stall,
             o_perf_bubble_cnt, o_perf_flush_cnt
   );

endinterface

// File: rtl/rv_hazard_lu.sv
// rtl/rv_hazard_lu.sv - combinational load-use comparator between EX load and Decode sources
module rv_hazard_lu
   import rv_id_ex_reg_pkg::*;
(
   input  logic                  i_ex_valid,
   input  logic                  i_ex_is_load,
   input  logic [REG_ADDR_W-1:0] i_ex_rd,
   input  logic                  i_id_valid,
   input  logic [REG_ADDR_W-1:0] i_id_rs1,
   input  logic                  i_id_rs1_use,
   input  logic [REG_ADDR_W-1:0] i_id_rs2,
   input  logic                  i_id_rs2_use,
   output logic                  o_lu
);

   logic ex_load_live;
   logic rs1_hit;
   logic rs2_hit;

   // x0 is hardwired, so a load targeting it never produces data anyone waits for.
   always_comb begin
      ex_load_live = i_ex_valid & i_ex_is_load & (i_ex_rd != '0);
      rs1_hit      = i_id_rs1_use & (i_id_rs1 == i_ex_rd);
      rs2_hit      = i_id_rs2_use & (i_id_rs2 == i_ex_rd);
      o_lu         = ex_load_live & i_id_valid & (rs1_hit | rs2_hit);
   end

endmodule

// File: rtl/rv_id_ex_reg.sv
// rtl/rv_id_ex_reg.sv - ID/EX pipeline register with load-use stall and flush bubbles
// Optional perf counters built when RV_IDEX_PERF_CNT_EN is defined.
module rv_id_ex_reg
   import rv_id_ex_reg_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   rv_id_ex_reg_if.slave  ex_bus
);

   ex_ctrl_t              id_ctrl;
   ex_ctrl_t              ctrl_d,     ctrl_q;
   logic [XLEN-1:0]       pc_d,       pc_q;
   logic [XLEN-1:0]       pc_plus_4_d, pc_plus_4_q;
   logic [XLEN-1:0]       rs1_data_d, rs1_data_q;
   logic [XLEN-1:0]       rs2_data_d, rs2_data_q;
   logic [XLEN-1:0]       imm_d,      imm_q;
   logic [REG_ADDR_W-1:0] rs1_d,      rs1_q;
   logic [REG_ADDR_W-1:0] rs2_d,      rs2_q;
   logic [REG_ADDR_W-1:0] rd_d,       rd_q;
   logic                  rs1_use_d,  rs1_use_q;
   logic                  rs2_use_d,  rs2_use_q;
   logic                  lu;
   logic                  load_bubble;
   logic                  load_flush;
   logic                  capture;

   rv_hazard_lu u_hazard_lu (
      .i_ex_valid   (ctrl_q.valid),
      .i_ex_is_load (ctrl_q.is_load),
      .i_ex_rd      (rd_q),
      .i_id_valid   (ex_bus.i_id_valid),
      .i_id_rs1     (ex_bus.i_id_rs1),
      .i_id_rs1_use (ex_bus.i_id_rs1_use),
      .i_id_rs2     (ex_bus.i_id_rs2),
      .i_id_rs2_use (ex_bus.i_id_rs2_use),
      .o_lu         (lu)
   );

   always_comb begin
      id_ctrl.valid         = ex_bus.i_id_valid;
      id_ctrl.is_load       = ex_bus.i_id_is_load;
      id_ctrl.alu_a_sel     = ex_bus.i_id_alu_a_sel;
      id_ctrl.alu_b_sel     = ex_bus.i_id_alu_b_sel;
      id_ctrl.dmem_we       = ex_bus.i_id_dmem_we;
      id_ctrl.rf_we         = ex_bus.i_id_rf_we;
      id_ctrl.alu_ctrl      = ex_bus.i_id_alu_ctrl;
      id_ctrl.dmem_bytectrl = ex_bus.i_id_dmem_bytectrl;
      id_ctrl.rf_wd_pre_sel = ex_bus.i_id_rf_wd_pre_sel;
      id_ctrl.is_br_jp      = ex_bus.i_id_is_br_jp;
   end

   // Flush beats hold; hold beats the load-use bubble; otherwise Decode advances.
   always_comb begin
      load_flush  = ex_bus.i_ex_flush;
      load_bubble = ~ex_bus.i_ex_flush & ~ex_bus.i_ex_hold & lu;
      capture     = ~ex_bus.i_ex_flush & ~ex_bus.i_ex_hold & ~lu;

      ctrl_d      = ctrl_q;
      pc_d        = pc_q;
      pc_plus_4_d = pc_plus_4_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rs1_use_d   = rs1_use_q;
      rs2_use_d   = rs2_use_q;

      if (load_flush || load_bubble) begin
         ctrl_d = make_bubble(ctrl_q);
      end else if (capture) begin
         ctrl_d      = ex_bus.i_id_valid ? id_ctrl : make_bubble(id_ctrl);
         pc_d        = ex_bus.i_id_pc;
         pc_plus_4_d = ex_bus.i_id_pc_plus_4;
         rs1_data_d  = ex_bus.i_id_rs1_data;
         rs2_data_d  = ex_bus.i_id_rs2_data;
         imm_d       = ex_bus.i_id_imm;
         rs1_d       = ex_bus.i_id_rs1;
         rs2_d       = ex_bus.i_id_rs2;
         rd_d        = ex_bus.i_id_rd;
         rs1_use_d   = ex_bus.i_id_rs1_use;
         rs2_use_d   = ex_bus.i_id_rs2_use;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         ctrl_q      <= '0;
         pc_q        <= '0;
         pc_plus_4_q <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_use_q   <= 1'b0;
         rs2_use_q   <= 1'b0;
      end else begin
         ctrl_q      <= ctrl_d;
         pc_q        <= pc_d;
         pc_plus_4_q <= pc_plus_4_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_use_q   <= rs1_use_d;
         rs2_use_q   <= rs2_use_d;
      end
   end

   // Stall is masked during reset so Fetch never sees a stale hazard from old EX state.
   assign ex_bus.o_id_stall = i_rstn & (lu | ex_bus.i_ex_hold) & ~ex_bus.i_ex_flush;

   assign ex_bus.o_ex_valid         = ctrl_q.valid;
   assign ex_bus.o_ex_is_load       = ctrl_q.is_load;
   assign ex_bus.o_ex_alu_a_sel     = ctrl_q.alu_a_sel;
   assign ex_bus.o_ex_alu_b_sel     = ctrl_q.alu_b_sel;
   assign ex_bus.o_ex_dmem_we       = ctrl_q.dmem_we;
   assign ex_bus.o_ex_rf_we         = ctrl_q.rf_we;
   assign ex_bus.o_ex_alu_ctrl      = ctrl_q.alu_ctrl;
   assign ex_bus.o_ex_dmem_bytectrl = ctrl_q.dmem_bytectrl;
   assign ex_bus.o_ex_rf_wd_pre_sel = ctrl_q.rf_wd_pre_sel;
   assign ex_bus.o_ex_is_br_jp      = ctrl_q.is_br_jp;
   assign ex_bus.o_ex_pc            = pc_q;
   assign ex_bus.o_ex_pc_plus_4     = pc_plus_4_q;
   assign ex_bus.o_ex_rs1_data      = rs1_data_q;
   assign ex_bus.o_ex_rs2_data      = rs2_data_q;
   assign ex_bus.o_ex_imm           = imm_q;
   assign ex_bus.o_ex_rs1           = rs1_q;
   assign ex_bus.o_ex_rs2           = rs2_q;
   assign ex_bus.o_ex_rd            = rd_q;
   assign ex_bus.o_ex_rs1_use       = rs1_use_q;
   assign ex_bus.o_ex_rs2_use       = rs2_use_q;

`ifdef RV_IDEX_PERF_CNT_EN
   logic [31:0] bubble_cnt_d, bubble_cnt_q;
   logic [31:0] flush_cnt_d,  flush_cnt_q;

   // Both counters stick at all-ones rather than wrapping.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      if (load_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
      if (load_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign ex_bus.o_perf_bubble_cnt = bubble_cnt_q;
   assign ex_bus.o_perf_flush_cnt  = flush_cnt_q;
`else
   assign ex_bus.o_perf_bubble_cnt = '0;
   assign ex_bus.o_perf_flush_cnt  = '0;
`endif

endmodule
